fetch_queue_unit: RTL

//  Instruction-fetch front end. Writes the IF/ID pipeline register.

---
 rtl/fetch_queue_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fetch_queue_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_queue_unit                                                |
// | Purpose  : Instruction-fetch front end. Issues in-order word fetches to    |
// |            instruction memory, buffers the returned words in a small       |
// |            queue and presents the head entry to the IF/ID register.        |
// |            Honours IF/ID stalls and flushes on an ID-stage redirect.       |
// | Ports    : clk, reset (async, active-low)                                  |
// |            imem_req/imem_addr/imem_ready   - request channel               |
// |            imem_rvalid/imem_rdata          - in-order response channel     |
// |            IF_IDWrite (1 = hold), redirect/redirect_pc                     |
// |            InstrF/PCF/PCPlus4F/FetchValid  - head entry to IF/ID           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fetch_queue_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          FQ_DEPTH  = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        IF_IDWrite,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        FetchValid
);

  localparam int c_CW = $clog2(FQ_DEPTH + 1);
  localparam int c_PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam logic [c_PW-1:0] c_LAST_IDX = c_PW'(FQ_DEPTH - 1);
  localparam logic [c_CW:0]   c_DEPTH    = (c_CW + 1)'(FQ_DEPTH);

  // Queue storage and bookkeeping
  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_resp_pc;
  logic [31:0]     r_q_pc    [FQ_DEPTH];
  logic [31:0]     r_q_instr [FQ_DEPTH];
  logic [c_PW-1:0] r_head;
  logic [c_PW-1:0] r_tail;
  logic [c_CW-1:0] r_count;
  logic [c_CW-1:0] r_outstanding;
  logic [c_CW-1:0] r_discard;

  logic [c_CW:0]   w_inflight;
  logic [c_CW-1:0] w_rv;
  logic            w_accept;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [c_CW-1:0] w_count_nxt;
  logic [c_CW-1:0] w_out_nxt;
  logic [c_CW-1:0] w_disc_nxt;

  function automatic logic [c_PW-1:0] f_inc(input logic [c_PW-1:0] p);
    return (p == c_LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  // Credit check: every buffered word plus every request still in flight
  // holds a queue slot, so a response can always be pushed.
  assign w_inflight = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_rv       = c_CW'(imem_rvalid);

  assign imem_req  = !redirect && reset && (w_inflight < c_DEPTH);
  assign imem_addr = r_fetch_pc;
  assign w_accept  = imem_req && imem_ready;

  assign w_pop  = !IF_IDWrite && (r_count != '0) && !redirect;
  assign w_drop = imem_rvalid && (r_discard != '0);
  assign w_push = imem_rvalid && (r_discard == '0) && !redirect;

  always_comb begin
    w_count_nxt = r_count;
    w_out_nxt   = r_outstanding;
    w_disc_nxt  = r_discard;
    if (redirect) begin
      w_count_nxt = '0;
      w_out_nxt   = r_outstanding - w_rv;
      // Every request still in flight after this cycle belongs to the old
      // path. Stale ones already counted in discard are part of outstanding,
      // so the new discard is simply what remains in flight.
      w_disc_nxt  = r_outstanding - w_rv;
    end else begin
      w_count_nxt = r_count + c_CW'(w_push) - c_CW'(w_pop);
      w_out_nxt   = r_outstanding + c_CW'(w_accept) - w_rv;
      w_disc_nxt  = r_discard - c_CW'(w_drop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        r_q_pc[i]    <= '0;
        r_q_instr[i] <= '0;
      end
    end else begin
      r_count       <= w_count_nxt;
      r_outstanding <= w_out_nxt;
      r_discard     <= w_disc_nxt;
      if (redirect) begin
        r_fetch_pc <= redirect_pc;
        r_resp_pc  <= redirect_pc;
        r_head     <= '0;
        r_tail     <= '0;
      end else begin
        if (w_accept) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_push) begin
          r_q_pc[r_tail]    <= r_resp_pc;
          r_q_instr[r_tail] <= imem_rdata;
          r_resp_pc         <= r_resp_pc + 32'd4;
          r_tail            <= f_inc(r_tail);
        end
        if (w_pop) begin
          r_head <= f_inc(r_head);
        end
      end
    end
  end

  // When empty, PCF shows the PC the next useful response will carry.
  always_comb begin
    FetchValid = (r_count != '0);
    InstrF     = FetchValid ? r_q_instr[r_head] : NOP_INSTR;
    PCF        = FetchValid ? r_q_pc[r_head] : r_resp_pc;
    PCPlus4F   = PCF + 32'd4;
  end

endmodule
`default_nettype wire
